// File: rtl/pp_pkg.sv
// Shared types and default sizes for the spectrum post-process path.
package pp_pkg;

  localparam int PP_DATA_W    = 16;
  localparam int PP_ADDR_W    = 9;
  localparam int PP_FRAME_LEN = 512;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    TAIL,
    WAIT_DONE
  } pp_state_e;

endpackage

// File: rtl/pp_rd_pipe.sv
// One-stage alignment of RAM read data with its delayed read strobe.
// data_out holds the last sample while the qualifier is low.
module pp_rd_pipe
  import pp_pkg::*;
#(
  parameter int DATA_W = PP_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid_out
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = rd_en;
    if (rd_en) data_d = rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data_out       = data_q;
  assign data_valid_out = vld_q;

endmodule

// File: rtl/pp_frame_sender.sv
// Streams one accumulated frame to post-processing and waits for done.
// Define PP_FRAME_TIMEOUT_EN to bound the wait for the done pulse.
module pp_frame_sender
  import pp_pkg::*;
#(
  parameter int DATA_W       = PP_DATA_W,
  parameter int ADDR_W       = PP_ADDR_W,
  parameter int FRAME_LEN    = PP_FRAME_LEN,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pp_ctrl,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid_out,
  input  logic              pp_done,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  if (FRAME_LEN < 1 || FRAME_LEN > (1 << ADDR_W) || DONE_TIMEOUT < 1)
  begin : g_bad_cfg
    $error("pp_frame_sender: illegal parameters");
  end

  pp_state_e         state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pp_ctrl_q, pp_ctrl_d;
  logic              frame_done_q, frame_done_d;
  logic              tmo_hit;

`ifdef PP_FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  assign tmo_hit = (tmo_q == TMO_W'(DONE_TIMEOUT - 1));

  always_comb begin
    tmo_d = '0;
    err_d = err_q;
    if (state_q == WAIT_DONE) tmo_d = tmo_q + 1'b1;
    if (state_q == IDLE && start) err_d = 1'b0;
    else if (state_q == WAIT_DONE && !pp_done && tmo_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rd_en_d      = rd_en_q;
    rd_addr_d    = rd_addr_q;
    cnt_d        = cnt_q;
    pp_ctrl_d    = pp_ctrl_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = STREAM;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          cnt_d     = '0;
          pp_ctrl_d = 1'b1;
        end
      end
      STREAM: begin
        // address wraps freely; the wider counter ends the frame
        rd_addr_d = rd_addr_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = TAIL;
          rd_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TAIL: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (pp_done) begin
          state_d      = IDLE;
          pp_ctrl_d    = 1'b0;
          frame_done_d = 1'b1;
        end else if (tmo_hit) begin
          state_d   = IDLE;
          pp_ctrl_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      cnt_q        <= '0;
      pp_ctrl_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      cnt_q        <= cnt_d;
      pp_ctrl_q    <= pp_ctrl_d;
      frame_done_q <= frame_done_d;
    end
  end

  pp_rd_pipe #(
    .DATA_W(DATA_W)
  ) u_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_en         (rd_en_q),
    .rd_data       (rd_data),
    .data_out      (data_out),
    .data_valid_out(data_valid_out)
  );

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign pp_ctrl    = pp_ctrl_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pp_frame_sender.sv
// Directed bench for pp_frame_sender: 8-word, 512-word and 1-word frames.
module tb_pp_frame_sender;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // 8-word instance, RAM[k] = k
  logic        start8 = 1'b0, rd_en8, ctrl8, vld8, busy8, fd8, err8;
  logic        done8 = 1'b0, v8 = 1'b0, rcv8 = 1'b1;
  logic [3:0]  addr8;
  logic [15:0] rdat8, dout8;
  assign rdat8 = {12'b0, addr8};

  pp_frame_sender #(
    .DATA_W(16), .ADDR_W(4), .FRAME_LEN(8), .DONE_TIMEOUT(16)
  ) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .rd_en(rd_en8),
    .rd_addr(addr8), .rd_data(rdat8), .pp_ctrl(ctrl8),
    .data_out(dout8), .data_valid_out(vld8), .pp_done(done8),
    .busy(busy8), .frame_done(fd8), .timeout_err(err8)
  );

  // full-depth instance, RAM[k] = k ^ A5A5
  logic        start5 = 1'b0, rd_en5, ctrl5, vld5, busy5, fd5, err5;
  logic        done5 = 1'b0, v5 = 1'b0;
  logic [8:0]  addr5;
  logic [15:0] rdat5, dout5;
  assign rdat5 = {7'b0, addr5} ^ 16'hA5A5;

  pp_frame_sender #(
    .DATA_W(16), .ADDR_W(9), .FRAME_LEN(512), .DONE_TIMEOUT(1024)
  ) u512 (
    .clk(clk), .rst_n(rst_n), .start(start5), .rd_en(rd_en5),
    .rd_addr(addr5), .rd_data(rdat5), .pp_ctrl(ctrl5),
    .data_out(dout5), .data_valid_out(vld5), .pp_done(done5),
    .busy(busy5), .frame_done(fd5), .timeout_err(err5)
  );

  // single-word instance, RAM[k] = 1234 + k
  logic        start1 = 1'b0, rd_en1, ctrl1, vld1, busy1, fd1, err1;
  logic        done1 = 1'b0, v1 = 1'b0;
  logic [8:0]  addr1;
  logic [15:0] rdat1, dout1;
  assign rdat1 = 16'h1234 + {7'b0, addr1};

  pp_frame_sender #(
    .DATA_W(16), .ADDR_W(9), .FRAME_LEN(1), .DONE_TIMEOUT(1024)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rd_en(rd_en1),
    .rd_addr(addr1), .rd_data(rdat1), .pp_ctrl(ctrl1),
    .data_out(dout1), .data_valid_out(vld1), .pp_done(done1),
    .busy(busy1), .frame_done(fd1), .timeout_err(err1)
  );

  // receivers: done pulse one cycle after valid falls
  always @(posedge clk) begin
    v8    <= vld8;
    done8 <= rcv8 && v8 && !vld8;
    v5    <= vld5;
    done5 <= v5 && !vld5;
    v1    <= vld1;
    done1 <= v1 && !vld1;
  end

  typedef struct {
    logic        vld;
    logic [15:0] dat;
    logic        ctrl;
    logic        fd;
    logic        busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int nv, nf, nr, first_v, last_v, fd_c;
    logic [15:0] last_d;

    for (int c = 0; c < 14; c++) begin
      tbl[c].vld  = (c >= 2 && c <= 9);
      tbl[c].dat  = (c < 2) ? 16'd0 : (c <= 9) ? 16'(c - 2) : 16'd7;
      tbl[c].ctrl = (c >= 1 && c <= 11);
      tbl[c].fd   = (c == 12);
      tbl[c].busy = (c >= 1 && c <= 11);
    end

    repeat (3) @(negedge clk);
    chk("rst rd_en", rd_en8, 0);
    chk("rst rd_addr", addr8, 0);
    chk("rst pp_ctrl", ctrl8, 0);
    chk("rst data_out", dout8, 0);
    chk("rst valid", vld8, 0);
    chk("rst busy", busy8, 0);
    chk("rst frame_done", fd8, 0);
    chk("rst timeout_err", err8, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic frame with lockout pulses at 5 and 11, relaunch at 13
    nv = 0; nf = 0;
    for (int c = 0; c <= 26; c++) begin
      if (c < 14) begin
        chk($sformatf("basic c%0d valid", c), vld8, tbl[c].vld);
        chk($sformatf("basic c%0d data", c), dout8, tbl[c].dat);
        chk($sformatf("basic c%0d ctrl", c), ctrl8, tbl[c].ctrl);
        chk($sformatf("basic c%0d fdone", c), fd8, tbl[c].fd);
        chk($sformatf("basic c%0d busy", c), busy8, tbl[c].busy);
      end
      if (c == 1) begin
        chk("basic c1 rd_en", rd_en8, 1);
        chk("basic c1 rd_addr", addr8, 0);
      end
      if (c == 14) begin
        chk("relaunch ctrl", ctrl8, 1);
        chk("relaunch rd_addr", addr8, 0);
      end
      if (c == 25) chk("relaunch fdone", fd8, 1);
      if (vld8) nv++;
      if (fd8) nf++;
      start8 = (c == 0 || c == 5 || c == 11 || c == 13);
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("lockout valid count", nv, 16);
    chk("lockout fdone count", nf, 2);

    // full-depth wrap
    nv = 0; nr = 0; first_v = -1; last_v = -1; fd_c = -1; last_d = '0;
    for (int c = 0; c <= 525; c++) begin
      if (vld5) begin
        nv++;
        if (first_v < 0) first_v = c;
        last_v = c;
        last_d = dout5;
      end
      if (rd_en5) nr++;
      if (fd5) fd_c = c;
      start5 = (c == 0);
      @(negedge clk);
    end
    start5 = 1'b0;
    chk("wrap valid count", nv, 512);
    chk("wrap read count", nr, 512);
    chk("wrap first valid", first_v, 2);
    chk("wrap last valid", last_v, 513);
    chk("wrap last data", last_d, 16'h01FF ^ 16'hA5A5);
    chk("wrap fdone cycle", fd_c, 516);
    chk("wrap rd_addr end", addr5, 0);
    chk("wrap busy end", busy5, 0);
    chk("wrap ctrl end", ctrl5, 0);
    chk("wrap err", err5, 0);

    // single word
    nv = 0; first_v = -1; fd_c = -1; last_d = '0;
    for (int c = 0; c <= 8; c++) begin
      if (vld1) begin
        nv++;
        first_v = c;
        last_d = dout1;
      end
      if (c == 1) chk("single rd_en c1", rd_en1, 1);
      if (c == 2) chk("single ctrl c2", ctrl1, 1);
      if (fd1) fd_c = c;
      start1 = (c == 0);
      @(negedge clk);
    end
    start1 = 1'b0;
    chk("single valid count", nv, 1);
    chk("single valid cycle", first_v, 2);
    chk("single data", last_d, 16'h1234);
    chk("single fdone cycle", fd_c, 5);
    chk("single busy end", busy1, 0);
    chk("single err", err1, 0);

    // mid-frame reset
    nf = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c == 3) chk("mid c3 valid", vld8, 1);
      if (c == 4) begin
        rst_n = 1'b0;
        #1;
        chk("mid rst valid", vld8, 0);
        chk("mid rst ctrl", ctrl8, 0);
        chk("mid rst busy", busy8, 0);
        chk("mid rst rd_en", rd_en8, 0);
        chk("mid rst data", dout8, 0);
        chk("mid rst rd_addr", addr8, 0);
      end
      if (c == 6) rst_n = 1'b1;
      if (fd8) nf++;
      start8 = (c == 0);
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("mid no fdone", nf, 0);

    nv = 0; fd_c = -1;
    for (int c = 0; c <= 13; c++) begin
      if (c == 1) chk("post rst rd_addr", addr8, 0);
      if (c == 2) begin
        chk("post rst valid", vld8, 1);
        chk("post rst data", dout8, 0);
      end
      if (vld8) nv++;
      if (fd8) fd_c = c;
      start8 = (c == 0);
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("post rst valid count", nv, 8);
    chk("post rst fdone cycle", fd_c, 12);

`ifdef PP_FRAME_TIMEOUT_EN
    rcv8 = 1'b0;
    nf = 0;
    for (int c = 0; c <= 29; c++) begin
      if (c == 25) begin
        chk("tmo c25 ctrl", ctrl8, 1);
        chk("tmo c25 err", err8, 0);
      end
      if (c == 26) begin
        chk("tmo c26 err", err8, 1);
        chk("tmo c26 ctrl", ctrl8, 0);
        chk("tmo c26 busy", busy8, 0);
      end
      if (c == 28) begin
        chk("tmo clear err", err8, 0);
        chk("tmo restart busy", busy8, 1);
      end
      if (fd8) nf++;
      start8 = (c == 0 || c == 27);
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("tmo no fdone", nf, 0);
    rcv8 = 1'b1;
    repeat (30) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pp_frame_sender.md
# pp_frame_sender

Streams one accumulated spectrum frame from the accumulation RAM to the post-processing stage as a contiguous `data_valid` burst. It frames the burst with the post-process control enable, then waits for the receiver's done pulse before going idle. It is the source end of the `Post_Process_Ctrl` / `data_valid_in` / `Post_Process_Done` handshake and sits between the spectrum accumulator RAM and the post-process chain.

## Interface
Parameters:
- `DATA_W`, 16: sample width.
- `ADDR_W`, 9: RAM address width.
- `FRAME_LEN`, 512: words per frame. Legal range is 1..2^ADDR_W.
- `DONE_TIMEOUT`, 1024: cycles allowed in WAIT_DONE (used only with `PP_FRAME_TIMEOUT_EN`).

Ports:
- `clk`, in, 1: sole clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle frame request.
- `rd_en`, out, 1: RAM read strobe.
- `rd_addr`, out, `ADDR_W`: RAM read address.
- `rd_data`, in, `DATA_W`: RAM data. Valid exactly 1 cycle after `rd_en`.
- `pp_ctrl`, out, 1: post-process enable, drives the receiver's `Post_Process_Ctrl`.
- `data_out`, out, `DATA_W`: streamed sample.
- `data_valid_out`, out, 1: sample qualifier, drives the receiver's `data_valid_in`.
- `pp_done`, in, 1: receiver's `Post_Process_Done` pulse.
- `busy`, out, 1: high in any state other than IDLE.
- `frame_done`, out, 1: one-cycle pulse when the frame is acknowledged.
- `timeout_err`, out, 1: sticky flag. Cleared by the next accepted `start`.

## Operation
- States:
  - **IDLE**: waiting for a request.
  - **STREAM**: reading the RAM.
  - **TAIL**: last RAM word in flight.
  - **WAIT_DONE**: waiting for the receiver.
- IDLE → STREAM on `start`=1. On entry, `pp_ctrl` is set and a read of address 0 is issued.
- In STREAM, `rd_en`=1 every cycle and `rd_addr` increments by 1. A separate `ADDR_W+1`-bit word counter detects the end of the frame, so `FRAME_LEN`=2^ADDR_W is legal and `rd_addr` wraps harmlessly to 0.
- After read `FRAME_LEN-1` is issued, go to TAIL, with `rd_en` low.
- TAIL → WAIT_DONE on the next cycle.
- Output stage:
  - `data_out` is the registered `rd_data`.
  - `data_valid_out` is `rd_en` delayed by 1 cycle.
  - The burst is exactly `FRAME_LEN` contiguous cycles with no gaps.
  - `data_out` holds its last value when not valid.
- WAIT_DONE → IDLE on `pp_done`=1. That same edge deasserts `pp_ctrl` and pulses `frame_done`.
- `pp_ctrl` stays high from the first read until the done pulse. It therefore covers the whole burst plus the receiver's done latency.
- `start` is ignored whenever `busy`=1, including the cycle in which `pp_done` is sampled.
- `pp_done` is ignored outside WAIT_DONE.
- Reset value of all outputs is 0. `rd_addr` resets to 0 and the state resets to IDLE.
- An `rst_n` assertion mid-frame aborts immediately: `data_valid_out` and `pp_ctrl` drop asynchronously and no `frame_done` is issued.

## Timing
- `start` sampled at edge 0:
  - `pp_ctrl` and `rd_en` are high from cycle 1, with `rd_addr`=0.
  - First `data_valid_out` is in cycle 2.
  - Last valid cycle is `FRAME_LEN+1`.
- The receiver raises `pp_done` 1 cycle after valid falls. `frame_done` therefore pulses in cycle `FRAME_LEN+4` and `busy` falls the same cycle.
- `FRAME_LEN`=1 gives one STREAM cycle, then TAIL, then a single-cycle burst.
- Minimum request-to-request spacing is `FRAME_LEN+4` cycles.

## Configuration
- `PP_FRAME_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DONE.
  - After `DONE_TIMEOUT` cycles without `pp_done`, the block sets `timeout_err`, drops `pp_ctrl`, and returns to IDLE without a `frame_done` pulse.
  - A `pp_done` arriving on the expiry cycle wins: the frame is acknowledged normally.
- Not defined:
  - WAIT_DONE waits indefinitely.
  - `timeout_err` is tied to 0.
  - `DONE_TIMEOUT` is unused.

## Structure
- Shared package `pp_pkg` holds:
  - the state enumeration (IDLE, STREAM, TAIL, WAIT_DONE);
  - default `DATA_W`, `ADDR_W` and `FRAME_LEN` constants, shared with the accumulator and the post-process stage.
- One sub-module, `pp_rd_pipe`: a 1-stage register aligning `rd_data` with the delayed `rd_en`. It produces `data_out` and `data_valid_out`, and is reusable if RAM latency grows.
- FSM and counters are in the top level.

## Test plan
- **Basic frame**: RAM[k]=k, `FRAME_LEN`=8, `start` at cycle 0, receiver model attached.
  - Valid is high in cycles 2..9.
  - `data_out` reads 0..7.
  - `frame_done` pulses in cycle 12.
  - `pp_ctrl` is high in cycles 1..11.
- **Full-depth wrap**: `FRAME_LEN`=512, `ADDR_W`=9.
  - Exactly 512 valid cycles.
  - Last `data_out`=RAM[511].
  - `rd_addr` ends at 0.
  - No 513th valid cycle.
- **Busy lockout**: `start` re-pulsed at cycle 5 and again on the `pp_done` cycle.
  - Both are ignored; exactly one frame is streamed.
  - A `start` one cycle after `frame_done` launches a new frame.
- **Mid-frame reset**: `rst_n` low at cycle 4 for 2 cycles.
  - All outputs 0 within the reset cycle.
  - No `frame_done`.
  - A subsequent `start` streams from address 0.
- **Timeout** (`PP_FRAME_TIMEOUT_EN`, `DONE_TIMEOUT`=16): receiver never pulses done.
  - `timeout_err`=1 and `pp_ctrl`=0 after 16 WAIT_DONE cycles; `busy`=0.
  - The next `start` clears `timeout_err`.
- **Single word**: `FRAME_LEN`=1.
  - Exactly one valid cycle, in cycle 2, carrying RAM[0].
  - `frame_done` in cycle 5.
